cen_mean_accumulator: RTL

Computes the per-channel mean of a block of N samples on the four whitening input channels and presents the means as `res1`..`res4` to the centering subtractor stage.
It sits directly upstream of that subtractor, which forms `Xcen = x - res`.
It accumulates unsigned 26-bit samples in widened accumulators and divides by a power-of-two N with a right shift.
It raises `En` once a valid mean set exists.

---
 rtl/cen_mean_accumulator_if.sv | 23 ++
 rtl/cen_mean_accumulator.sv | 89 ++++++++
 2 files changed

// File: rtl/cen_mean_accumulator_if.sv
// Sample/mean bundle between the whitening front end, the mean accumulator and the
// centering subtractor.
interface cen_mean_accumulator_if #(
    parameter int W = 26
);
    logic         GO;
    logic         x_valid;
    logic [W-1:0] x1_in, x2_in, x3_in, x4_in;
    logic [W-1:0] res1, res2, res3, res4;
    logic         En;
    logic         done;
    logic         busy;

    modport master (
        output GO, x_valid, x1_in, x2_in, x3_in, x4_in,
        input  res1, res2, res3, res4, En, done, busy
    );

    modport slave (
        input  GO, x_valid, x1_in, x2_in, x3_in, x4_in,
        output res1, res2, res3, res4, En, done, busy
    );
endinterface

// File: rtl/cen_mean_accumulator.sv
// Per-channel block mean over N = 2^LOG2_N samples on four channels; means are held
// registered and only replaced on the single DIVIDE cycle.
module cen_mean_accumulator #(
    parameter int W      = 26,
    parameter int LOG2_N = 8
) (
    input  logic clk,
    input  logic rst,
    cen_mean_accumulator_if.slave bus
);
    localparam int NUM_LANES = 4;
    localparam int AW        = W + LOG2_N;

    typedef enum logic [1:0] {IDLE, ACCUM, DIVIDE} state_t;

    state_t                          state;
    logic [LOG2_N-1:0]               cnt;
    logic                            en_q, done_q, busy_q;
    logic [NUM_LANES-1:0][W-1:0]     x;
    logic [NUM_LANES-1:0][W-1:0]     res;
    logic                            clr, add, load;

    assign x = {bus.x4_in, bus.x3_in, bus.x2_in, bus.x1_in};

    assign clr  = (state == IDLE) && bus.GO;
    assign add  = (state == ACCUM) && bus.x_valid;
    assign load = (state == DIVIDE);

    // Counter wraps to zero on the Nth sample, so all-ones is the terminal count.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            en_q   <= 1'b0;
            done_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.GO) begin
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (bus.x_valid) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == '1) state <= DIVIDE;
                    end
                end
                DIVIDE: begin
                    done_q <= 1'b1;
                    en_q   <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        logic [AW-1:0] acc;
        logic [W-1:0]  mean;

        always_ff @(posedge clk) begin
            if (rst) begin
                acc  <= '0;
                mean <= '0;
            end else begin
                if (clr)      acc <= '0;
                else if (add) acc <= acc + AW'(x[k]);
                if (load)     mean <= acc[AW-1:LOG2_N];
            end
        end

        assign res[k] = mean;
    end

    assign bus.res1 = res[0];
    assign bus.res2 = res[1];
    assign bus.res3 = res[2];
    assign bus.res4 = res[3];
    assign bus.En   = en_q;
    assign bus.done = done_q;
    assign bus.busy = busy_q;
endmodule
